node_state_tally: RTL and testbench
===================================

NODE_STATE_TALLY -- requirements
Module: node_state_tally

Interface
REQ-001 Parameter NUM_NODES, default 10, number of network nodes monitored (1..64).
REQ-002 Parameter CNT_W, default 32, width of each per-node infected-tick counter.
REQ-003 Parameter TICK_W, default 16, width of tick counter and tick limit.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse: clear statistics and begin a run.
REQ-007 stop  input  1  pulse: end the current run early.
REQ-008 tickEn  input  1  current cycle is a simulation tick; states sampled only when high.
REQ-009 tickLimit  input  TICK_W  ticks per run; 0 means free-run until stop.
REQ-010 states  input  NUM_NODES  per-node infected flag from the network (bit i = node i).
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE.
REQ-013 tickCount  output  TICK_W  ticks counted in current or last run.
REQ-014 infectedNow  output  clog2(NUM_NODES+1)  popcount of states at last counted tick.
REQ-015 peakInfected  output  clog2(NUM_NODES+1)  maximum infectedNow in the run.
REQ-016 peakTick  output  TICK_W  tick number (1-based) of first occurrence of peakInfected.
REQ-017 rdReq  input  1  readout request.
REQ-018 rdAddr  input  clog2(NUM_NODES)  node index to read (minimum width 1).
REQ-019 rdValid  output  1  rdData valid, exactly one cycle after rdReq.
REQ-020 rdData  output  CNT_W  infected-tick count of node rdAddr.

Function
REQ-021 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-022 IDLE/DONE + start: clear all node counters, tickCount, infectedNow, peakInfected, peakTick in the same edge; enter RUN next cycle.
REQ-023 start while in RUN is ignored.
REQ-024 RUN + tickEn: tickCount += 1; for each i with states[i]=1, counter[i] += 1, saturating at 2^CNT_W-1; infectedNow <= popcount(states).
REQ-025 RUN + tickEn=0: no statistic changes.
REQ-026 Peak: when a counted tick's popcount is strictly greater than peakInfected, update peakInfected and set peakTick to the new tickCount value; ties keep the earlier tick.
REQ-027 RUN -> DONE on the edge where the counted tick brings tickCount to tickLimit (tickLimit != 0); that tick is included.
REQ-028 RUN + stop -> DONE; if tickEn also high that cycle, the tick is counted first.
REQ-029 stop and start in the same cycle: start wins in IDLE/DONE, stop wins in RUN.
REQ-030 tickCount saturates at 2^TICK_W-1 in free-run; run continues until stop.
REQ-031 tickLimit sampled every cycle; lowering it below tickCount mid-run has no effect until stop.
REQ-032 Readout allowed in any state; rdData reflects counter value before the edge on which rdReq was sampled.
REQ-033 rdAddr >= NUM_NODES returns rdData=0 with rdValid=1.
REQ-034 Back-to-back rdReq every cycle yields rdValid every cycle (one per request, in order).
REQ-035 rdData holds its last value when rdValid is low.

Reset
REQ-036 resetN low: immediately state IDLE, busy=0, done=0, rdValid=0, rdData=0, tickCount=0, infectedNow=0, peakInfected=0, peakTick=0, all counters 0.
REQ-037 Reset asserted mid-run aborts the run; no partial statistics survive; first start after release behaves as from power-up.

Verification
REQ-038 NUM_NODES=10, tickLimit=500, states=10'b0000000001 constant, tickEn=1 -> done after 500 ticks; counter[0]=500, counters 1..9=0, peakInfected=1, peakTick=1.
REQ-039 tickLimit=4, popcounts per tick 2,5,5,3 -> peakInfected=5, peakTick=2, infectedNow=3, tickCount=4.
REQ-040 tickLimit=0, tickEn toggling every other cycle for 20 cycles then stop -> tickCount=10, busy falls, done=1.
REQ-041 CNT_W=4, node 3 high for 20 ticks -> counter[3]=15 (saturated); read rdAddr=12 -> rdData=0, rdValid=1.
REQ-042 rdReq on node 0 in the same cycle its counter increments from 7 -> rdData=7 next cycle; immediate re-read -> 8.
REQ-043 resetN pulsed low at tick 100 of a 500-tick run -> all outputs 0 asynchronously, IDLE; new start runs full 500 ticks.

Source files
------------

// File: rtl/node_state_tally_if.sv
// Readout bus for node_state_tally.
// Master issues rdReq/rdAddr, slave returns rdValid/rdData.
interface node_state_tally_if #(
  parameter int NUM_NODES = 10,
  parameter int CNT_W     = 32
);
  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic             rdReq;
  logic [AW-1:0]    rdAddr;
  logic             rdValid;
  logic [CNT_W-1:0] rdData;

  modport master (
    output rdReq,
    output rdAddr,
    input  rdValid,
    input  rdData
  );

  modport slave (
    input  rdReq,
    input  rdAddr,
    output rdValid,
    output rdData
  );
endinterface

// File: rtl/node_state_tally.sv
// Per-node infection statistics over a tick-based run.
// Tracks tick count, current/peak infected and per-node counters.
module node_state_tally #(
  parameter int  NUM_NODES = 10,
  parameter int  CNT_W     = 32,
  parameter int  TICK_W    = 16,
  localparam int PW = $clog2(NUM_NODES + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                start,
  input  logic                stop,
  input  logic                tickEn,
  input  logic [TICK_W-1:0]   tickLimit,
  input  logic [NUM_NODES-1:0] states,
  output logic                busy,
  output logic                done,
  output logic [TICK_W-1:0]   tickCount,
  output logic [PW-1:0]       infectedNow,
  output logic [PW-1:0]       peakInfected,
  output logic [TICK_W-1:0]   peakTick,
  node_state_tally_if.slave   rd
);

  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;
  logic [TICK_W-1:0] peak_tick_q;
  logic [PW-1:0]     now_q;
  logic [PW-1:0]     peak_q;
  logic [PW-1:0]     pop_d;
  logic              clr_d;
  logic              cnt_en_d;
  logic              fin_d;

  logic [CNT_W-1:0]  cnt_q [NUM_NODES];
  logic [CNT_W-1:0]  rd_sel_d;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_valid_q;

  // Number of infected nodes in the current sample.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      pop_d = pop_d + PW'(states[i]);
    end
  end

  // Saturating next tick value and run control decodes.
  always_comb begin
    tick_d = tick_q;
    if (tick_q != '1) begin
      tick_d = tick_q + TICK_W'(1);
    end
    clr_d    = start && (state_q != RUN);
    cnt_en_d = (state_q == RUN) && tickEn;
    fin_d    = stop
            || (tickEn
                && (tickLimit != '0)
                && (tick_d == tickLimit));
  end

  // Run FSM with registered status and run statistics.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= '0;
      now_q       <= '0;
      peak_q      <= '0;
      peak_tick_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            tick_q      <= '0;
            now_q       <= '0;
            peak_q      <= '0;
            peak_tick_q <= '0;
          end
        end
        RUN: begin
          if (tickEn) begin
            tick_q <= tick_d;
            now_q  <= pop_d;
            if (pop_d > peak_q) begin
              peak_q      <= pop_d;
              peak_tick_q <= tick_d;
            end
          end
          if (fin_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-node saturating infected-tick counters.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_NODES; i++) begin
        if (clr_d) begin
          cnt_q[i] <= '0;
        end else if (cnt_en_d
                     && states[i]
                     && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Readout mux; unmapped addresses read as zero.
  always_comb begin
    rd_sel_d = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (rd.rdAddr == AW'(i)) begin
        rd_sel_d = cnt_q[i];
      end
    end
  end

  // One-cycle readout; data holds between requests.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd.rdReq;
      if (rd.rdReq) begin
        rd_data_q <= rd_sel_d;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign tickCount    = tick_q;
  assign infectedNow  = now_q;
  assign peakInfected = peak_q;
  assign peakTick     = peak_tick_q;
  assign rd.rdValid   = rd_valid_q;
  assign rd.rdData    = rd_data_q;

endmodule

// File: tb/tb_node_state_tally.sv
// Self-checking bench for node_state_tally.
// Readout results are scoreboarded through a queue.
module tb_node_state_tally;

  logic clk;
  logic resetN;

  logic        start, stop, tickEn;
  logic [15:0] tickLimit;
  logic [9:0]  states;
  logic        busy, done;
  logic [15:0] tickCount, peakTick;
  logic [3:0]  infectedNow, peakInfected;

  logic        b_start, b_stop, b_tickEn;
  logic [3:0]  b_tickLimit;
  logic [9:0]  b_states;
  logic        b_busy, b_done;
  logic [3:0]  b_tickCount, b_peakTick;
  logic [3:0]  b_infectedNow, b_peakInfected;

  node_state_tally_if #(.NUM_NODES(10), .CNT_W(32)) a_if ();
  node_state_tally_if #(.NUM_NODES(10), .CNT_W(4))  b_if ();

  node_state_tally #(
    .NUM_NODES(10), .CNT_W(32), .TICK_W(16)
  ) dut_a (
    .clk(clk), .resetN(resetN),
    .start(start), .stop(stop), .tickEn(tickEn),
    .tickLimit(tickLimit), .states(states),
    .busy(busy), .done(done), .tickCount(tickCount),
    .infectedNow(infectedNow), .peakInfected(peakInfected),
    .peakTick(peakTick), .rd(a_if)
  );

  node_state_tally #(
    .NUM_NODES(10), .CNT_W(4), .TICK_W(4)
  ) dut_b (
    .clk(clk), .resetN(resetN),
    .start(b_start), .stop(b_stop), .tickEn(b_tickEn),
    .tickLimit(b_tickLimit), .states(b_states),
    .busy(b_busy), .done(b_done), .tickCount(b_tickCount),
    .infectedNow(b_infectedNow), .peakInfected(b_peakInfected),
    .peakTick(b_peakTick), .rd(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mdl [10];
  logic [31:0] exp_q [$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) mdl[i] = '0;
  endtask

  function automatic logic [31:0] mdl_val(input int a);
    return (a < 10) ? mdl[a] : 32'd0;
  endfunction

  task automatic test_reset();
    resetN = 1'b0;
    #3;
    n_chk++;
    if ({busy, done, a_if.rdValid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {busy, done, a_if.rdValid});
    end
    n_chk++;
    if ({tickCount, peakTick, infectedNow, peakInfected} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h want 0",
               {tickCount, peakTick, infectedNow, peakInfected});
    end
    n_chk++;
    if (a_if.rdData !== 32'd0 || b_tickCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_rd: got %h/%h want 0", a_if.rdData, b_tickCount);
    end
    cyc();
    cyc();
    resetN = 1'b1;
    cyc();
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back_read(input int lo, input int hi);
    logic [31:0] last;
    last = '0;
    a_if.rdReq = 1'b1;
    a_if.rdAddr = 4'(lo);
    exp_q.push_back(mdl_val(lo));
    for (int k = lo + 1; k <= hi + 1; k++) begin
      cyc();
      if (exp_q.size() != 0) last = exp_q.pop_front();
      n_chk++;
      if (a_if.rdValid !== 1'b1) begin
        n_fail++;
        $display("FAIL rd_valid[%0d]: got %b want 1", k - 1, a_if.rdValid);
      end
      n_chk++;
      if (a_if.rdData !== last) begin
        n_fail++;
        $display("FAIL rd_data[%0d]: got %0d want %0d",
                 k - 1, a_if.rdData, last);
      end
      if (k <= hi) begin
        a_if.rdAddr = 4'(k);
        exp_q.push_back(mdl_val(k));
      end else begin
        a_if.rdReq = 1'b0;
      end
    end
    cyc();
    n_chk++;
    if (a_if.rdValid !== 1'b0 || a_if.rdData !== last) begin
      n_fail++;
      $display("FAIL rd_hold: got v=%b d=%0d want v=0 d=%0d",
               a_if.rdValid, a_if.rdData, last);
    end
  endtask

  task automatic test_single_node();
    int n;
    tickLimit = 16'd500;
    states = 10'b0000000001;
    tickEn = 1'b1;
    start_a();
    n_chk++;
    if (busy !== 1'b1 || tickCount !== 16'd0) begin
      n_fail++;
      $display("FAIL run_entry: got busy=%b tc=%0d want 1 0", busy, tickCount);
    end
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      cyc();
      n++;
      if (tickEn && mdl[0] < 500) mdl[0] = mdl[0] + 1;
    end
    tickEn = 1'b0;
    n_chk++;
    if (n != 500 || tickCount !== 16'd500 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got cycles=%0d tc=%0d busy=%b want 500 500 0",
               n, tickCount, busy);
    end
    n_chk++;
    if (peakInfected !== 4'd1 || peakTick !== 16'd1 || infectedNow !== 4'd1)
    begin
      n_fail++;
      $display("FAIL single_peak: got pk=%0d pt=%0d now=%0d want 1 1 1",
               peakInfected, peakTick, infectedNow);
    end
    for (int i = 1; i < 10; i++) begin
      test_back_to_back_read(i, i);
    end
    test_back_to_back_read(0, 9);
  endtask

  task automatic test_peak();
    logic [9:0] p [4];
    logic [9:0] pat;
    p[0] = 10'b0000000011;
    p[1] = 10'b1111100000;
    p[2] = 10'b0101010101;
    p[3] = 10'b0000111000;
    tickLimit = 16'd4;
    states = '0;
    tickEn = 1'b0;
    start_a();
    for (int k = 0; k < 4; k++) begin
      pat = p[k];
      states = pat;
      tickEn = 1'b1;
      for (int i = 0; i < 10; i++) mdl[i] = mdl[i] + 32'(pat[i]);
      cyc();
      tickEn = 1'b0;
      if (k == 0) begin
        states = '1;
        cyc();
        n_chk++;
        if (tickCount !== 16'd1 || infectedNow !== 4'd2) begin
          n_fail++;
          $display("FAIL no_tick_hold: got tc=%0d now=%0d want 1 2",
                   tickCount, infectedNow);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || tickCount !== 16'd1) begin
          n_fail++;
          $display("FAIL start_in_run: got busy=%b tc=%0d want 1 1",
                   busy, tickCount);
        end
      end
    end
    n_chk++;
    if (done !== 1'b1 || tickCount !== 16'd4) begin
      n_fail++;
      $display("FAIL peak_done: got done=%b tc=%0d want 1 4", done, tickCount);
    end
    n_chk++;
    if (peakInfected !== 4'd5 || peakTick !== 16'd2 || infectedNow !== 4'd3)
    begin
      n_fail++;
      $display("FAIL peak_vals: got pk=%0d pt=%0d now=%0d want 5 2 3",
               peakInfected, peakTick, infectedNow);
    end
    test_back_to_back_read(0, 9);
  endtask

  task automatic test_free_run();
    tickLimit = 16'd0;
    states = 10'b0000000110;
    start_a();
    for (int i = 0; i < 20; i++) begin
      tickEn = (i % 2 == 0);
      cyc();
    end
    tickEn = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || tickCount !== 16'd10) begin
      n_fail++;
      $display("FAIL free_run: got busy=%b tc=%0d want 1 10", busy, tickCount);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b1 || tickCount !== 16'd10) begin
      n_fail++;
      $display("FAIL free_stop: got busy=%b done=%b tc=%0d want 0 1 10",
               busy, done, tickCount);
    end
  endtask

  task automatic test_stop();
    tickLimit = 16'd10;
    states = '0;
    tickEn = 1'b1;
    start_a();
    for (int i = 0; i < 5; i++) cyc();
    tickLimit = 16'd3;
    for (int i = 0; i < 10; i++) cyc();
    n_chk++;
    if (busy !== 1'b1 || tickCount !== 16'd15) begin
      n_fail++;
      $display("FAIL limit_lowered: got busy=%b tc=%0d want 1 15",
               busy, tickCount);
    end
    stop = 1'b1;
    start = 1'b1;
    cyc();
    tickEn = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || tickCount !== 16'd16) begin
      n_fail++;
      $display("FAIL stop_wins_run: got done=%b busy=%b tc=%0d want 1 0 16",
               done, busy, tickCount);
    end
    cyc();
    stop = 1'b0;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0 || tickCount !== 16'd0) begin
      n_fail++;
      $display("FAIL start_wins_done: got busy=%b done=%b tc=%0d want 1 0 0",
               busy, done, tickCount);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_read_during_tick();
    logic [31:0] e;
    tickLimit = 16'd0;
    states = 10'b0000000001;
    tickEn = 1'b1;
    start_a();
    for (int i = 0; i < 7; i++) begin
      cyc();
      mdl[0] = mdl[0] + 1;
    end
    a_if.rdReq = 1'b1;
    a_if.rdAddr = 4'd0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mdl[0]);
      cyc();
      mdl[0] = mdl[0] + 1;
      e = exp_q.pop_front();
      n_chk++;
      if (a_if.rdValid !== 1'b1 || a_if.rdData !== e) begin
        n_fail++;
        $display("FAIL rd_same_edge[%0d]: got v=%b d=%0d want v=1 d=%0d",
                 k, a_if.rdValid, a_if.rdData, e);
      end
    end
    a_if.rdReq = 1'b0;
    tickEn = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    test_back_to_back_read(0, 1);
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    b_tickLimit = 4'd0;
    b_states = 10'b0000001000;
    b_tickEn = 1'b1;
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    b_tickEn = 1'b0;
    n_chk++;
    if (b_busy !== 1'b1 || b_tickCount !== 4'd15) begin
      n_fail++;
      $display("FAIL tick_sat: got busy=%b tc=%0d want 1 15",
               b_busy, b_tickCount);
    end
    n_chk++;
    if (b_peakInfected !== 4'd1 || b_peakTick !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_peak: got pk=%0d pt=%0d want 1 1",
               b_peakInfected, b_peakTick);
    end
    b_if.rdReq = 1'b1;
    b_if.rdAddr = 4'd3;
    exp_q.push_back(32'd15);
    cyc();
    b_if.rdAddr = 4'd12;
    exp_q.push_back(32'd0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        cyc();
        b_if.rdReq = 1'b0;
      end
      e = exp_q.pop_front();
      n_chk++;
      if (b_if.rdValid !== 1'b1 || b_if.rdData !== e[3:0]) begin
        n_fail++;
        $display("FAIL sat_read[%0d]: got v=%b d=%0d want v=1 d=%0d",
                 k, b_if.rdValid, b_if.rdData, e[3:0]);
      end
    end
    b_stop = 1'b1;
    cyc();
    b_stop = 1'b0;
    n_chk++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_stop: got done=%b busy=%b want 1 0", b_done, b_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [31:0] e;
    tickLimit = 16'd500;
    states = 10'b0000000001;
    tickEn = 1'b1;
    start_a();
    for (int i = 0; i < 100; i++) begin
      if (i == 99) begin
        a_if.rdReq = 1'b1;
        a_if.rdAddr = 4'd0;
        exp_q.push_back(mdl[0]);
      end
      cyc();
      mdl[0] = mdl[0] + 1;
    end
    a_if.rdReq = 1'b0;
    e = exp_q.pop_front();
    n_chk++;
    if (a_if.rdValid !== 1'b1 || a_if.rdData !== e || tickCount !== 16'd100)
    begin
      n_fail++;
      $display("FAIL pre_reset: got v=%b d=%0d tc=%0d want 1 %0d 100",
               a_if.rdValid, a_if.rdData, tickCount, e);
    end
    #2;
    resetN = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, a_if.rdValid} !== 3'b000 || a_if.rdData !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_flags: got %b d=%0d want 000 d=0",
               {busy, done, a_if.rdValid}, a_if.rdData);
    end
    n_chk++;
    if ({tickCount, peakTick, infectedNow, peakInfected} !== 40'd0) begin
      n_fail++;
      $display("FAIL async_reset_stats: got %h want 0",
               {tickCount, peakTick, infectedNow, peakInfected});
    end
    cyc();
    resetN = 1'b1;
    tickEn = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) mdl[i] = '0;
    test_back_to_back_read(0, 2);
    tickEn = 1'b1;
    start_a();
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      cyc();
      n++;
      if (mdl[0] < 500) mdl[0] = mdl[0] + 1;
    end
    tickEn = 1'b0;
    n_chk++;
    if (n != 500 || tickCount !== 16'd500) begin
      n_fail++;
      $display("FAIL rerun_full: got cycles=%0d tc=%0d want 500 500",
               n, tickCount);
    end
    test_back_to_back_read(0, 1);
  endtask

  initial begin
    start = 0; stop = 0; tickEn = 0; tickLimit = '0; states = '0;
    b_start = 0; b_stop = 0; b_tickEn = 0; b_tickLimit = '0; b_states = '0;
    a_if.rdReq = 0; a_if.rdAddr = '0;
    b_if.rdReq = 0; b_if.rdAddr = '0;
    resetN = 1'b0;
    test_reset();
    test_single_node();
    test_peak();
    test_free_run();
    test_stop();
    test_read_during_tick();
    test_saturation();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
